// File: rtl/fir_ctrl_pkg.sv
// Shared types and default sizes for the FIR block sequencer.
package fir_ctrl_pkg;

   localparam int FC_DATA_W  = 16;
   localparam int FC_ADDR_W  = 10;
   localparam int FC_FIR_LAT = 2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } state_t;

endpackage

// File: rtl/fir_ctrl_skid.sv
// Two-entry sample FIFO between the sample RAM read port and the FIR input.
module fir_ctrl_skid
   import fir_ctrl_pkg::*;
#(
   parameter int DATA_W = FC_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_head,
   output logic [1:0]        o_count,
   output logic              o_empty
);

   logic [DATA_W-1:0] r_mem [2];
   logic              r_rd_ptr;
   logic              r_wr_ptr;
   logic [1:0]        r_count;
   logic              w_do_pop;
   logic              w_do_push;

   assign w_do_pop  = i_pop && (r_count != 2'd0);
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_clr) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/fir_seq_ctrl.sv
// Block sequencer: streams a sample RAM block through the FIR, flushes it
// with zeros and writes the filtered block to the result RAM.
module fir_seq_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int DATA_W  = FC_DATA_W,
   parameter int ADDR_W  = FC_ADDR_W,
   parameter int FIR_LAT = FC_FIR_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              fir_clk_en,
   output logic [DATA_W-1:0] fir_in,
   input  logic [DATA_W-1:0] fir_out,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ready
);

   localparam int               CNT_W = ADDR_W + 2;
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(FIR_LAT);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   r_rd_cnt;
   logic [CNT_W-1:0]  r_step_cnt;
   logic              r_rd_pend;

   logic              w_accept;
   logic              w_kill;
   logic              w_rd;
   logic              w_step;
   logic              w_wr;
   logic              w_push;
   logic              w_pop;
   logic              w_empty;
   logic [1:0]        w_count;
   logic [DATA_W-1:0] w_head;
   logic [CNT_W-1:0]  w_len_x;

   assign w_len_x  = {1'b0, r_len};
   assign w_accept = start && (r_state == IDLE);
   assign w_kill   = abort && (r_state != IDLE);

   // Keep held + in-flight samples within the two buffer slots, counting the
   // slot freed by a step in this same cycle.
   assign w_rd = !w_kill && (r_state == RUN) && (r_rd_cnt < r_len) &&
                 (({1'b0, w_count} + {2'b0, r_rd_pend}) < (3'd2 + {2'b0, w_step}));

   // Backpressure only matters once the FIR output carries real results.
   assign w_step = !w_kill &&
                   (((r_state == RUN) && !w_empty) || (r_state == FLUSH)) &&
                   ((r_step_cnt < LAT_C) || wr_ready);

   assign w_wr   = w_step && (r_step_cnt >= LAT_C);
   assign w_pop  = w_step && (r_state == RUN);
   assign w_push = r_rd_pend && (r_state == RUN) && !w_kill;

   fir_ctrl_skid #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_kill || w_accept),
      .i_push  (w_push),
      .i_data  (rd_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = (len == '0) ? DONE : RUN;
         RUN:     if (w_step && (r_step_cnt == w_len_x - CNT_W'(1))) w_state_nxt = FLUSH;
         FLUSH:   if (w_step && (r_step_cnt == w_len_x + LAT_C - CNT_W'(1))) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (w_kill) w_state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_len      <= '0;
         r_rd_cnt   <= '0;
         r_step_cnt <= '0;
         r_rd_pend  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_pend <= w_rd;
         if (w_accept) begin
            r_len      <= len;
            r_rd_cnt   <= '0;
            r_step_cnt <= '0;
         end else begin
            if (w_rd)   r_rd_cnt   <= r_rd_cnt + 1'b1;
            if (w_step) r_step_cnt <= r_step_cnt + 1'b1;
         end
      end
   end

   assign busy       = (r_state != IDLE);
   assign done       = (r_state == DONE);
   assign rd_en      = w_rd;
   assign rd_addr    = ADDR_W'(r_rd_cnt);
   assign fir_clk_en = w_step;
   assign fir_in     = ((r_state == RUN) && !w_empty) ? w_head : '0;
   assign wr_en      = w_wr;
   assign wr_addr    = w_wr ? ADDR_W'(r_step_cnt - LAT_C) : '0;
   assign wr_data    = w_wr ? fir_out : '0;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with a sync-read sample RAM and a 2-step FIR delay model.
module tb_fir_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [10:0] len;
   logic        abort;
   logic        busy;
   logic        done;
   logic        rd_en;
   logic [9:0]  rd_addr;
   logic [15:0] rd_data = 16'h0;
   logic        fir_clk_en;
   logic [15:0] fir_in;
   logic [15:0] fir_out;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [15:0] wr_data;
   logic        wr_ready;
   logic        inject;

   logic [15:0] ram [1024];
   logic [15:0] f1 = 16'h0;
   logic [15:0] f2 = 16'h0;

   int n_chk = 0;
   int n_err = 0;

   int n_rd, n_done, done_cyc, idle_cyc, late_step, late_wr;
   int step_cyc[$];
   int step_val[$];
   int wr_cyc[$];
   int wr_adr[$];
   int wr_dat[$];
   int rd_cyc[$];
   int rd_adr[$];

   always #5 clk = ~clk;

   fir_seq_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .fir_clk_en (fir_clk_en),
      .fir_in     (fir_in),
      .fir_out    (fir_out),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready)
   );

   always @(posedge clk) begin
      if (rd_en) rd_data <= ram[rd_addr];
      else if (inject) rd_data <= 16'h7777;
   end

   always @(posedge clk) begin
      if (fir_clk_en) begin
         f1 <= fir_in;
         f2 <= f1;
      end
   end
   assign fir_out = f2;

   // Cycle 0 is the cycle whose closing edge accepts start.
   task automatic run_block(input int blen, input int ab_cyc, input int st_lo, input int st_hi,
                            input int bs_cyc, input int bs_len, input int inj_cyc, input int maxc);
      int cyc;
      n_rd = 0; n_done = 0; done_cyc = -1; idle_cyc = -1; late_step = 0; late_wr = 0;
      step_cyc.delete(); step_val.delete();
      wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
      rd_cyc.delete(); rd_adr.delete();
      @(negedge clk);
      start = 1'b1; len = 11'(blen); abort = 1'b0; wr_ready = 1'b1; inject = 1'b0;
      cyc = 0;
      while (cyc < maxc && !(idle_cyc >= 0 && cyc >= idle_cyc + 1)) begin
         cyc++;
         @(negedge clk);
         start    = (cyc == bs_cyc);
         len      = (cyc == bs_cyc) ? 11'(bs_len) : 11'(blen);
         abort    = (cyc == ab_cyc);
         wr_ready = !(cyc >= st_lo && cyc <= st_hi);
         inject   = (cyc == inj_cyc - 1);
         #1;
         if (rd_en) begin
            n_rd++;
            rd_cyc.push_back(cyc);
            rd_adr.push_back(int'(rd_addr));
         end
         if (fir_clk_en) begin
            step_cyc.push_back(cyc);
            step_val.push_back(int'(fir_in));
         end
         if (wr_en) begin
            wr_cyc.push_back(cyc);
            wr_adr.push_back(int'(wr_addr));
            wr_dat.push_back(int'(wr_data));
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (!busy && idle_cyc < 0) idle_cyc = cyc;
         if (ab_cyc > 0 && cyc > ab_cyc) begin
            if (fir_clk_en) late_step++;
            if (wr_en) late_wr++;
         end
      end
      start = 1'b0; abort = 1'b0; wr_ready = 1'b1; inject = 1'b0; len = 11'd0;
   endtask

   task automatic test_reset();
      n_chk++;
      if ({busy, done, rd_en, fir_clk_en, wr_en} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, rd_en, fir_clk_en, wr_en});
      end
      n_chk++;
      if (rd_addr !== 10'd0 || wr_addr !== 10'd0) begin
         n_err++;
         $display("FAIL reset_addr: got rd %0d wr %0d expected 0 0", rd_addr, wr_addr);
      end
      n_chk++;
      if (fir_in !== 16'd0 || wr_data !== 16'd0) begin
         n_err++;
         $display("FAIL reset_data: got fir_in %0d wr_data %0d expected 0 0", fir_in, wr_data);
      end
   endtask

   task automatic test_basic();
      int exp_in[6] = '{1, 2, 3, 4, 0, 0};
      run_block(4, -1, 0, -1, -1, 0, -10, 40);
      n_chk++;
      if (step_val.size() != 6) begin
         n_err++;
         $display("FAIL basic_nstep: got %0d expected 6", step_val.size());
      end
      for (int i = 0; i < 6 && i < step_val.size(); i++) begin
         n_chk++;
         if (step_cyc[i] != 3 + i || step_val[i] != exp_in[i]) begin
            n_err++;
            $display("FAIL basic_step%0d: got cycle %0d fir_in %0d expected cycle %0d fir_in %0d",
                     i, step_cyc[i], step_val[i], 3 + i, exp_in[i]);
         end
      end
      n_chk++;
      if (wr_cyc.size() != 4) begin
         n_err++;
         $display("FAIL basic_nwr: got %0d expected 4", wr_cyc.size());
      end
      for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
         n_chk++;
         if (wr_cyc[i] != 5 + i || wr_adr[i] != i || wr_dat[i] != i + 1) begin
            n_err++;
            $display("FAIL basic_wr%0d: got cycle %0d addr %0d data %0d expected cycle %0d addr %0d data %0d",
                     i, wr_cyc[i], wr_adr[i], wr_dat[i], 5 + i, i, i + 1);
         end
      end
      n_chk++;
      if (n_rd != 4 || rd_cyc.size() < 2 || rd_cyc[0] != 1 || rd_adr[0] != 0 || rd_cyc[1] != 2 || rd_adr[1] != 1) begin
         n_err++;
         $display("FAIL basic_reads: got count %0d expected 4 with addr 0 in cycle 1 and addr 1 in cycle 2", n_rd);
      end
      n_chk++;
      if (done_cyc != 9 || n_done != 1 || idle_cyc != 10) begin
         n_err++;
         $display("FAIL basic_done: got done cycle %0d pulses %0d idle %0d expected 9 1 10", done_cyc, n_done, idle_cyc);
      end
   endtask

   task automatic test_backpressure();
      int exp_c[6] = '{3, 4, 8, 9, 10, 11};
      int exp_in[6] = '{1, 2, 3, 4, 0, 0};
      run_block(4, -1, 5, 7, -1, 0, -10, 40);
      n_chk++;
      if (step_cyc.size() != 6) begin
         n_err++;
         $display("FAIL bp_nstep: got %0d expected 6", step_cyc.size());
      end
      for (int i = 0; i < 6 && i < step_cyc.size(); i++) begin
         n_chk++;
         if (step_cyc[i] != exp_c[i] || step_val[i] != exp_in[i]) begin
            n_err++;
            $display("FAIL bp_step%0d: got cycle %0d fir_in %0d expected cycle %0d fir_in %0d",
                     i, step_cyc[i], step_val[i], exp_c[i], exp_in[i]);
         end
      end
      for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
         n_chk++;
         if (wr_cyc[i] != 8 + i || wr_adr[i] != i || wr_dat[i] != i + 1) begin
            n_err++;
            $display("FAIL bp_wr%0d: got cycle %0d addr %0d data %0d expected cycle %0d addr %0d data %0d",
                     i, wr_cyc[i], wr_adr[i], wr_dat[i], 8 + i, i, i + 1);
         end
      end
      n_chk++;
      if (wr_cyc.size() != 4 || n_rd != 4 || done_cyc != 12) begin
         n_err++;
         $display("FAIL bp_totals: got writes %0d reads %0d done cycle %0d expected 4 4 12",
                  wr_cyc.size(), n_rd, done_cyc);
      end
   endtask

   task automatic test_len_zero();
      run_block(0, -1, 0, -1, -1, 0, -10, 20);
      n_chk++;
      if (done_cyc != 1 || n_done != 1 || idle_cyc != 2) begin
         n_err++;
         $display("FAIL len0_done: got done cycle %0d pulses %0d idle %0d expected 1 1 2", done_cyc, n_done, idle_cyc);
      end
      n_chk++;
      if (n_rd != 0 || step_cyc.size() != 0 || wr_cyc.size() != 0) begin
         n_err++;
         $display("FAIL len0_activity: got reads %0d steps %0d writes %0d expected 0 0 0",
                  n_rd, step_cyc.size(), wr_cyc.size());
      end
   endtask

   task automatic test_max_len();
      int bad;
      run_block(1024, -1, 0, -1, -1, 0, -10, 1100);
      n_chk++;
      if (n_rd != 1024 || step_cyc.size() != 1026 || wr_cyc.size() != 1024) begin
         n_err++;
         $display("FAIL max_counts: got reads %0d steps %0d writes %0d expected 1024 1026 1024",
                  n_rd, step_cyc.size(), wr_cyc.size());
      end
      bad = 0;
      for (int i = 0; i < wr_adr.size(); i++)
         if (wr_adr[i] != i || wr_dat[i] != ((i + 1) & 16'hFFFF)) bad++;
      n_chk++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL max_order: got %0d out-of-order or wrong writes expected 0", bad);
      end
      n_chk++;
      if (done_cyc != 1029) begin
         n_err++;
         $display("FAIL max_done: got cycle %0d expected 1029", done_cyc);
      end
   endtask

   task automatic test_abort();
      int exp_in[6] = '{1, 2, 3, 4, 0, 0};
      run_block(8, 6, 0, -1, -1, 0, 7, 40);
      n_chk++;
      if (idle_cyc != 7 || n_done != 0) begin
         n_err++;
         $display("FAIL abort_idle: got idle cycle %0d done pulses %0d expected 7 0", idle_cyc, n_done);
      end
      n_chk++;
      if (late_wr != 0 || late_step != 0) begin
         n_err++;
         $display("FAIL abort_quiet: got late writes %0d late steps %0d expected 0 0", late_wr, late_step);
      end
      run_block(4, -1, 0, -1, -1, 0, -10, 40);
      n_chk++;
      if (step_val.size() != 6) begin
         n_err++;
         $display("FAIL abort_rerun_nstep: got %0d expected 6", step_val.size());
      end
      for (int i = 0; i < 6 && i < step_val.size(); i++) begin
         n_chk++;
         if (step_cyc[i] != 3 + i || step_val[i] != exp_in[i]) begin
            n_err++;
            $display("FAIL abort_rerun_step%0d: got cycle %0d fir_in %0d expected cycle %0d fir_in %0d",
                     i, step_cyc[i], step_val[i], 3 + i, exp_in[i]);
         end
      end
      n_chk++;
      if (wr_cyc.size() != 4 || done_cyc != 9 || (wr_dat.size() > 0 && wr_dat[0] != 1)) begin
         n_err++;
         $display("FAIL abort_rerun_wr: got writes %0d done cycle %0d expected 4 writes starting with 1 and done 9",
                  wr_cyc.size(), done_cyc);
      end
   endtask

   task automatic test_start_busy();
      run_block(8, -1, 0, -1, 4, 2, -10, 40);
      n_chk++;
      if (wr_cyc.size() != 8 || n_rd != 8 || done_cyc != 13 || n_done != 1) begin
         n_err++;
         $display("FAIL busy_start: got writes %0d reads %0d done cycle %0d pulses %0d expected 8 8 13 1",
                  wr_cyc.size(), n_rd, done_cyc, n_done);
      end
      n_chk++;
      if (wr_adr.size() != 8 || wr_adr[7] != 7 || wr_dat[7] != 8) begin
         n_err++;
         $display("FAIL busy_last_wr: got %0d writes expected last addr 7 data 8", wr_adr.size());
      end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      start = 1'b1; len = 11'd8; wr_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_chk++;
      if (busy !== 1'b1 || fir_clk_en !== 1'b1) begin
         n_err++;
         $display("FAIL midrun_active: got busy %b step %b expected 1 1", busy, fir_clk_en);
      end
      rst_n = 1'b0;
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_chk++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin
         n_err++;
         $display("FAIL midrun_after: got busy %b rd_en %b expected 0 0", busy, rd_en);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 16'(i + 1);
      rst_n = 1'b0; start = 1'b0; len = 11'd0; abort = 1'b0; wr_ready = 1'b1; inject = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_basic();
      test_backpressure();
      test_len_zero();
      test_max_len();
      test_abort();
      test_start_busy();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
